array_pq_gen: RTL and testbench
===============================

Name: array_pq_gen

Overview:
- Parametrised, single-cycle-insert sorted-array priority queue; successor to the fixed 8x8 array PQ.
- Generalised in depth and data width, with a selectable min/max ordering mode.
- Adds ID allocation from a free pool, same-cycle push+pop (replace while full), FIFO tie-breaking and synchronous flush.
- Sits between schedulers/producers and a single consumer. Head element is always presented registered on the pop port.

Parameters:
- DEPTH, 8, number of entries; >=2.
- DATA_WIDTH, 8, priority/data field width.
- MIN_FIRST, 1, 1: smallest data at head; 0: largest data at head.
- ID_WIDTH, $clog2(DEPTH), entry ID width; the ID pool is 0..DEPTH-1.
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of all entries.
- push_valid_i  in  1  push request.
- push_ready_o  out  1  push can be accepted this cycle.
- push_data_i  in  DATA_WIDTH  data/priority to insert.
- push_id_o  out  ID_WIDTH  ID that will be assigned if the push fires this cycle.
- pop_valid_o  out  1  head entry valid.
- pop_ready_i  in  1  consumer takes the head.
- pop_data_o  out  DATA_WIDTH  head data.
- pop_id_o  out  ID_WIDTH  head ID.
- count_o  out  CNT_WIDTH  occupancy.
- empty_o  out  1  count_o==0.
- full_o  out  1  count_o==DEPTH.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Storage: DEPTH cells {valid, data, id}. Cell 0 is the head. Valid cells are contiguous from cell 0, sorted by priority.
- Reset: all cells invalid, data/id 0, count 0, ID-free bitmap all free.
  - Outputs during and after reset: pop_valid_o=0, pop_data_o=0, pop_id_o=0, count_o=0, empty_o=1, full_o=0, push_id_o=0, push_ready_o=1.
- Handshakes:
  - pop_fire = pop_valid_o & pop_ready_i & !flush_i.
  - push_fire = push_valid_i & push_ready_o.
  - push_ready_o = !flush_i & (!full_o | pop_ready_i). The combinational path pop_ready_i->push_ready_o is intended.
- Pop outputs come straight from cell 0 registers: zero-latency, no combinational dependence on push.
- Push latency: the pushed entry is visible in the array, count_o and (if highest priority) pop_* in the next cycle.
- Ordering: entry A precedes B if A.data < B.data (MIN_FIRST=1) or A.data > B.data (MIN_FIRST=0).
  - Equal data: older entry first, so a new entry is placed behind all equal entries.
- Insert, push only: new entry goes to the first position whose data is strictly lower priority. Later entries shift one cell toward the tail.
- Pop only: all cells shift one toward the head; the tail cell becomes invalid.
- Push+pop same cycle: the head is removed and the new entry is inserted into the remaining set, in one cycle. count_o is unchanged. Legal when full.
- ID allocation:
  - push_id_o = lowest-numbered ID in (free bitmap OR id of head when pop_ready_i & pop_valid_o).
  - On push_fire that ID is marked used. On pop_fire the head ID is marked free.
  - A popped ID may be reused by a push in the same cycle.
  - IDs of live entries are always unique.
- Counter:
  - count_o += push_fire - pop_fire.
  - Never exceeds DEPTH; never underflows, because pop_valid_o is low when empty.
- Empty boundaries:
  - pop_ready_i while empty: no effect.
  - Push into an empty queue lands in cell 0.
- Full: push without pop_ready_i is refused (push_ready_o=0); state is unchanged.
- flush_i:
  - Next cycle all cells are invalid, count 0, all IDs free.
  - Overrides a coincident push/pop: neither fires, so no ID is consumed.
- Reset mid-operation: immediate return to the reset state; in-flight handshakes are discarded.
- Implementation: per-cell compare against push_data_i feeding a shift/hold/load mux, selected by the pop_fire and push_fire combination. No multi-cycle FSM.

Test Plan:
- Reset -> push 5,3,7,3 (MIN_FIRST=1), one per cycle -> head sequence on pops: (3,id1),(3,id3),(5,id0),(7,id2); count goes 4->0; empty_o=1 at the end.
- Fill to DEPTH=8 with data 10..17 -> full_o=1, push_ready_o=0 with pop_ready_i=0. Then push 4 with pop_ready_i=1 -> head 10 popped, 4 becomes head next cycle, count stays 8, new push_id_o equals the popped ID.
- MIN_FIRST=0, push 2,9,9,1 -> pops give 9 (older ID) then 9, 2, 1.
- Pop with empty queue and pop_ready_i=1 for 3 cycles -> count_o stays 0, pop_valid_o=0, no ID change.
- Queue holding 3 entries; assert flush_i together with push_valid_i and pop_ready_i -> next cycle count 0, empty_o=1, push_id_o=0, no entry inserted.
- Assert rst_ni low mid-burst (count 5) -> outputs return to reset values asynchronously. First push after release gets ID 0.

Source files
------------

// File: rtl/array_pq_gen_if.sv
// Producer/consumer bus for the sorted-array priority queue.
interface array_pq_gen_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned CNT_WIDTH  = 4
);
  logic                  flush_i;
  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [DATA_WIDTH-1:0] push_data_i;
  logic [ID_WIDTH-1:0]   push_id_o;
  logic                  pop_valid_o;
  logic                  pop_ready_i;
  logic [DATA_WIDTH-1:0] pop_data_o;
  logic [ID_WIDTH-1:0]   pop_id_o;
  logic [CNT_WIDTH-1:0]  count_o;
  logic                  empty_o;
  logic                  full_o;

  // Producer/consumer side.
  modport master (
    output flush_i, push_valid_i, push_data_i, pop_ready_i,
    input  push_ready_o, push_id_o, pop_valid_o, pop_data_o, pop_id_o,
           count_o, empty_o, full_o
  );

  // Queue side.
  modport slave (
    input  flush_i, push_valid_i, push_data_i, pop_ready_i,
    output push_ready_o, push_id_o, pop_valid_o, pop_data_o, pop_id_o,
           count_o, empty_o, full_o
  );
endinterface

// File: rtl/array_pq_gen.sv
// Sorted-array priority queue: single-cycle insert, pop, or replace (push+pop).
// Cell 0 is always the head; valid cells are contiguous from cell 0 and kept in
// priority order, with equal priorities in arrival order.
module array_pq_gen #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          MIN_FIRST  = 1'b1,
  parameter int unsigned ID_WIDTH   = $clog2(DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input logic           clk_i,
  input logic           rst_ni,
  array_pq_gen_if.slave bus
);

  // Cell storage.
  logic [DEPTH-1:0]      r_valid;
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [ID_WIDTH-1:0]   r_id   [DEPTH];
  logic [DEPTH-1:0]      r_free;
  logic [CNT_WIDTH-1:0]  r_count;

  // Next-state.
  logic [DEPTH-1:0]      w_valid_d;
  logic [DATA_WIDTH-1:0] w_data_d [DEPTH];
  logic [ID_WIDTH-1:0]   w_id_d   [DEPTH];
  logic [DEPTH-1:0]      w_free_d;
  logic [CNT_WIDTH-1:0]  w_count_d;

  // Neighbour views of the array, used by the shift muxes.
  logic [DEPTH-1:0]      w_up_valid;
  logic [DATA_WIDTH-1:0] w_up_data [DEPTH];
  logic [ID_WIDTH-1:0]   w_up_id   [DEPTH];
  logic [DEPTH-1:0]      w_dn_valid;
  logic [DATA_WIDTH-1:0] w_dn_data [DEPTH];
  logic [ID_WIDTH-1:0]   w_dn_id   [DEPTH];

  // w_ahead[i]: cell i stays in front of the incoming entry. Bit DEPTH is a
  // permanently-empty virtual cell past the tail.
  logic [DEPTH:0]        w_ahead;
  logic [DEPTH-1:0]      w_ahead_prev;
  logic [DEPTH-1:0]      w_ahead_next;
  logic [DEPTH-1:0]      w_ahead_self;

  logic                  w_full;
  logic                  w_push_ready;
  logic                  w_push_fire;
  logic                  w_pop_fire;
  logic [DEPTH-1:0]      w_head_mask;
  logic [DEPTH-1:0]      w_free_eff;
  logic [ID_WIDTH-1:0]   w_push_id;
  logic                  w_id_found;
  logic [DEPTH-1:0]      w_pop_mask;
  logic [DEPTH-1:0]      w_push_mask;

  assign w_full       = (r_count == CNT_WIDTH'(DEPTH));
  assign w_push_ready = !bus.flush_i && (!w_full || bus.pop_ready_i);
  assign w_push_fire  = bus.push_valid_i && w_push_ready;
  assign w_pop_fire   = r_valid[0] && bus.pop_ready_i && !bus.flush_i;

  // Head ID is offered to the producer as soon as the consumer is taking it.
  assign w_head_mask  = (bus.pop_ready_i && r_valid[0]) ? (DEPTH'(1) << r_id[0]) : '0;
  assign w_free_eff   = r_free | w_head_mask;
  assign w_pop_mask   = w_pop_fire ? (DEPTH'(1) << r_id[0]) : '0;
  assign w_push_mask  = w_push_fire ? (DEPTH'(1) << w_push_id) : '0;

  // Lowest-numbered available ID.
  always_comb begin
    w_push_id  = '0;
    w_id_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_id_found && w_free_eff[i]) begin
        w_push_id  = ID_WIDTH'(i);
        w_id_found = 1'b1;
      end
    end
  end

  // Per-cell priority compare; ties keep the old entry in front.
  always_comb begin
    w_ahead = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (MIN_FIRST) begin
        w_ahead[i] = r_valid[i] && (r_data[i] <= bus.push_data_i);
      end else begin
        w_ahead[i] = r_valid[i] && (r_data[i] >= bus.push_data_i);
      end
    end
  end

  // Position i is the insert point when the previous cell is still ahead (cell 0 has a
  // virtual always-ahead predecessor). For replace, cell 0 leaves, so the test for
  // position i uses cell i itself as its predecessor.
  assign w_ahead_prev = {w_ahead[DEPTH-2:0], 1'b1};
  assign w_ahead_next = w_ahead[DEPTH:1];
  assign w_ahead_self = {w_ahead[DEPTH-1:1], 1'b1};

  // Shifted copies of the array; out-of-range neighbours read as empty.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_up_valid[i] = 1'b0;
      w_up_data[i]  = '0;
      w_up_id[i]    = '0;
      w_dn_valid[i] = 1'b0;
      w_dn_data[i]  = '0;
      w_dn_id[i]    = '0;
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_up_valid[i] = r_valid[i+1];
      w_up_data[i]  = r_data[i+1];
      w_up_id[i]    = r_id[i+1];
    end
    for (int i = 1; i < DEPTH; i++) begin
      w_dn_valid[i] = r_valid[i-1];
      w_dn_data[i]  = r_data[i-1];
      w_dn_id[i]    = r_id[i-1];
    end
  end

  // Per-cell hold/shift/load select.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_valid_d[i] = r_valid[i];
      w_data_d[i]  = r_data[i];
      w_id_d[i]    = r_id[i];
    end
    if (bus.flush_i) begin
      w_valid_d = '0;
    end else begin
      case ({w_push_fire, w_pop_fire})
        2'b10: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (!w_ahead[i]) begin
              if (w_ahead_prev[i]) begin
                w_valid_d[i] = 1'b1;
                w_data_d[i]  = bus.push_data_i;
                w_id_d[i]    = w_push_id;
              end else begin
                w_valid_d[i] = w_dn_valid[i];
                w_data_d[i]  = w_dn_data[i];
                w_id_d[i]    = w_dn_id[i];
              end
            end
          end
        end
        2'b01: begin
          for (int i = 0; i < DEPTH; i++) begin
            w_valid_d[i] = w_up_valid[i];
            w_data_d[i]  = w_up_data[i];
            w_id_d[i]    = w_up_id[i];
          end
        end
        2'b11: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (w_ahead_next[i]) begin
              w_valid_d[i] = w_up_valid[i];
              w_data_d[i]  = w_up_data[i];
              w_id_d[i]    = w_up_id[i];
            end else if (w_ahead_self[i]) begin
              w_valid_d[i] = 1'b1;
              w_data_d[i]  = bus.push_data_i;
              w_id_d[i]    = w_push_id;
            end
          end
        end
        default: ;
      endcase
    end
    // Empty cells read as zero so an empty head presents zero data/id.
    for (int i = 0; i < DEPTH; i++) begin
      if (!w_valid_d[i]) begin
        w_data_d[i] = '0;
        w_id_d[i]   = '0;
      end
    end
  end

  // Free-pool and occupancy next state; a popped ID may be reclaimed by the same-cycle push.
  always_comb begin
    w_free_d  = (r_free | w_pop_mask) & ~w_push_mask;
    w_count_d = r_count + CNT_WIDTH'(w_push_fire) - CNT_WIDTH'(w_pop_fire);
    if (bus.flush_i) begin
      w_free_d  = '1;
      w_count_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
      r_free  <= '1;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_id[i]   <= '0;
      end
    end else begin
      r_valid <= w_valid_d;
      r_free  <= w_free_d;
      r_count <= w_count_d;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= w_data_d[i];
        r_id[i]   <= w_id_d[i];
      end
    end
  end

  assign bus.push_ready_o = w_push_ready;
  assign bus.push_id_o    = w_push_id;
  assign bus.pop_valid_o  = r_valid[0];
  assign bus.pop_data_o   = r_data[0];
  assign bus.pop_id_o     = r_id[0];
  assign bus.count_o      = r_count;
  assign bus.empty_o      = (r_count == '0);
  assign bus.full_o       = w_full;

  // Structural invariants: contiguous valid prefix, count tracks it, array sorted.
  logic w_sorted;

  // Sortedness of adjacent valid pairs.
  always_comb begin
    w_sorted = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (r_valid[i+1]) begin
        if (MIN_FIRST && (r_data[i] > r_data[i+1])) w_sorted = 1'b0;
        if (!MIN_FIRST && (r_data[i] < r_data[i+1])) w_sorted = 1'b0;
      end
    end
  end

  a_prefix: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_valid & (r_valid + DEPTH'(1))) == '0);
  a_count: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $countones(r_valid) == int'(r_count));
  a_sorted: assert property (@(posedge clk_i) disable iff (!rst_ni) w_sorted);

endmodule

// File: tb/tb_array_pq_gen.sv
// Bench for array_pq_gen: one min-first and one max-first instance share stimulus and are
// compared every cycle against an unsorted-bag model (head = best priority, then oldest).
module tb_array_pq_gen;

  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  logic flush;
  logic push_valid;
  logic [7:0] push_data;
  logic pop_ready;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  array_pq_gen_if #(.DATA_WIDTH(8), .ID_WIDTH(3), .CNT_WIDTH(4)) if_min ();
  array_pq_gen_if #(.DATA_WIDTH(8), .ID_WIDTH(3), .CNT_WIDTH(4)) if_max ();

  assign if_min.flush_i      = flush;
  assign if_min.push_valid_i = push_valid;
  assign if_min.push_data_i  = push_data;
  assign if_min.pop_ready_i  = pop_ready;
  assign if_max.flush_i      = flush;
  assign if_max.push_valid_i = push_valid;
  assign if_max.push_data_i  = push_data;
  assign if_max.pop_ready_i  = pop_ready;

  array_pq_gen #(.DEPTH(8), .DATA_WIDTH(8), .MIN_FIRST(1'b1)) u_dut_min (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if_min)
  );

  array_pq_gen #(.DEPTH(8), .DATA_WIDTH(8), .MIN_FIRST(1'b0)) u_dut_max (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (if_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: per instance (0 = min-first, 1 = max-first) an unordered bag with arrival stamps.
  int m_cnt  [2];
  int m_data [2][DEPTH];
  int m_id   [2][DEPTH];
  int m_seq  [2][DEPTH];
  bit m_used [2][DEPTH];
  int seq_ctr = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int head_idx(input int k);
    int best = 0;
    for (int j = 1; j < m_cnt[k]; j++) begin
      bit better;
      if (k == 0) better = m_data[k][j] < m_data[k][best];
      else        better = m_data[k][j] > m_data[k][best];
      if (m_data[k][j] == m_data[k][best] && m_seq[k][j] < m_seq[k][best]) better = 1;
      if (better) best = j;
    end
    return best;
  endfunction

  function automatic int exp_push_id(input int k);
    int hid = -1;
    if (pop_ready && m_cnt[k] > 0) hid = m_id[k][head_idx(k)];
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_used[k][i] || i == hid) return i;
    end
    return 0;
  endfunction

  function automatic int exp_push_ready(input int k);
    return (!flush && (m_cnt[k] < DEPTH || pop_ready)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      for (int i = 0; i < DEPTH; i++) m_used[k][i] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit pf;
      bit sf;
      int pid;
      pf  = (m_cnt[k] > 0) && pop_ready && !flush;
      sf  = push_valid && (exp_push_ready(k) == 1);
      pid = exp_push_id(k);
      if (flush) begin
        m_cnt[k] = 0;
        for (int i = 0; i < DEPTH; i++) m_used[k][i] = 0;
      end else begin
        if (pf) begin
          int h = head_idx(k);
          m_used[k][m_id[k][h]] = 0;
          m_data[k][h] = m_data[k][m_cnt[k]-1];
          m_id[k][h]   = m_id[k][m_cnt[k]-1];
          m_seq[k][h]  = m_seq[k][m_cnt[k]-1];
          m_cnt[k]--;
        end
        if (sf) begin
          m_data[k][m_cnt[k]] = int'(push_data);
          m_id[k][m_cnt[k]]   = pid;
          m_seq[k][m_cnt[k]]  = seq_ctr;
          m_used[k][pid] = 1;
          m_cnt[k]++;
          seq_ctr++;
        end
      end
    end
  endtask

  task automatic compare_one(input string tag, input int k, input int pv, input int pd,
                             input int pi, input int cnt, input int emp, input int full,
                             input int pr, input int pid);
    check({tag, " pop_valid"}, pv, (m_cnt[k] > 0) ? 1 : 0);
    if (m_cnt[k] > 0) begin
      check({tag, " pop_data"}, pd, m_data[k][head_idx(k)]);
      check({tag, " pop_id"}, pi, m_id[k][head_idx(k)]);
    end
    check({tag, " count"}, cnt, m_cnt[k]);
    check({tag, " empty"}, emp, (m_cnt[k] == 0) ? 1 : 0);
    check({tag, " full"}, full, (m_cnt[k] == DEPTH) ? 1 : 0);
    check({tag, " push_ready"}, pr, exp_push_ready(k));
    check({tag, " push_id"}, pid, exp_push_id(k));
  endtask

  // Per-cycle compare, midway between active edges.
  always @(negedge clk) begin
    if (chk_en) begin
      compare_one("min", 0, int'(if_min.pop_valid_o), int'(if_min.pop_data_o),
                  int'(if_min.pop_id_o), int'(if_min.count_o), int'(if_min.empty_o),
                  int'(if_min.full_o), int'(if_min.push_ready_o), int'(if_min.push_id_o));
      compare_one("max", 1, int'(if_max.pop_valid_o), int'(if_max.pop_data_o),
                  int'(if_max.pop_id_o), int'(if_max.count_o), int'(if_max.empty_o),
                  int'(if_max.full_o), int'(if_max.push_ready_o), int'(if_max.push_id_o));
    end
  end

  task automatic drive(input bit pv, input int pd, input bit pr, input bit fl);
    push_valid = pv;
    push_data  = 8'(pd);
    pop_ready  = pr;
    flush      = fl;
  endtask

  // Advance one clock; called from posedge+1, returns at the next posedge+1.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle(input bit pv, input int pd, input bit pr, input bit fl);
    drive(pv, pd, pr, fl);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rst pop_valid"}, int'(if_min.pop_valid_o), 0);
    check({tag, " rst pop_data"}, int'(if_min.pop_data_o), 0);
    check({tag, " rst pop_id"}, int'(if_min.pop_id_o), 0);
    check({tag, " rst count"}, int'(if_min.count_o), 0);
    check({tag, " rst empty"}, int'(if_min.empty_o), 1);
    check({tag, " rst full"}, int'(if_min.full_o), 0);
    check({tag, " rst push_id"}, int'(if_min.push_id_o), 0);
    check({tag, " rst push_ready"}, int'(if_min.push_ready_o), 1);
    check({tag, " rst max count"}, int'(if_max.count_o), 0);
  endtask

  initial begin
    int ed[4];
    int ei[4];
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("init");
    rst_n = 1'b1;

    // Min-first ordering with FIFO ties.
    cycle(1, 5, 0, 0);
    cycle(1, 3, 0, 0);
    cycle(1, 7, 0, 0);
    cycle(1, 3, 0, 0);
    check("seq1 count", int'(if_min.count_o), 4);
    ed = '{3, 3, 5, 7};
    ei = '{1, 3, 0, 2};
    for (int j = 0; j < 4; j++) begin
      check("seq1 head data", int'(if_min.pop_data_o), ed[j]);
      check("seq1 head id", int'(if_min.pop_id_o), ei[j]);
      check("seq1 count", int'(if_min.count_o), 4 - j);
      cycle(0, 0, 1, 0);
    end
    check("seq1 empty", int'(if_min.empty_o), 1);

    // Fill, refuse push when full, then replace.
    for (int j = 0; j < DEPTH; j++) cycle(1, 10 + j, 0, 0);
    drive(1, 4, 0, 0);
    #1;
    check("full flag", int'(if_min.full_o), 1);
    check("full push_ready", int'(if_min.push_ready_o), 0);
    tick();
    check("full unchanged head", int'(if_min.pop_data_o), 10);
    drive(1, 4, 1, 0);
    #1;
    check("replace push_ready", int'(if_min.push_ready_o), 1);
    check("replace push_id", int'(if_min.push_id_o), 0);
    tick();
    check("replace head data", int'(if_min.pop_data_o), 4);
    check("replace head id", int'(if_min.pop_id_o), 0);
    check("replace count", int'(if_min.count_o), 8);
    for (int j = 0; j < DEPTH; j++) cycle(0, 0, 1, 0);

    // Max-first ordering with FIFO ties.
    cycle(1, 2, 0, 0);
    cycle(1, 9, 0, 0);
    cycle(1, 9, 0, 0);
    cycle(1, 1, 0, 0);
    ed = '{9, 9, 2, 1};
    ei = '{1, 2, 0, 3};
    for (int j = 0; j < 4; j++) begin
      check("max head data", int'(if_max.pop_data_o), ed[j]);
      check("max head id", int'(if_max.pop_id_o), ei[j]);
      cycle(0, 0, 1, 0);
    end

    // Pop while empty.
    for (int j = 0; j < 3; j++) begin
      cycle(0, 0, 1, 0);
      check("empty pop count", int'(if_min.count_o), 0);
      check("empty pop valid", int'(if_min.pop_valid_o), 0);
      check("empty pop push_id", int'(if_min.push_id_o), 0);
    end

    // Flush overrides coincident push and pop.
    cycle(1, 1, 0, 0);
    cycle(1, 2, 0, 0);
    cycle(1, 3, 0, 0);
    cycle(1, 5, 1, 1);
    check("flush count", int'(if_min.count_o), 0);
    check("flush empty", int'(if_min.empty_o), 1);
    check("flush push_id", int'(if_min.push_id_o), 0);
    check("flush pop_valid", int'(if_max.pop_valid_o), 0);

    // Random traffic; small data range forces ties.
    for (int n = 0; n < 3000; n++) begin
      int pv_pct = (n < 1500) ? 70 : 45;
      int dmax   = (n % 500 < 250) ? 15 : 255;
      cycle($urandom_range(0, 99) < pv_pct, $urandom_range(0, dmax),
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 2);
    end
    for (int j = 0; j < DEPTH; j++) cycle(0, 0, 0, 1);

    // Asynchronous reset in the middle of a burst.
    for (int j = 0; j < 5; j++) cycle(1, 20 - j, 0, 0);
    check("burst count", int'(if_min.count_o), 5);
    drive(1, 33, 1, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("midrst");
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 9, 0, 0);
    #1;
    check("post-rst push_id", int'(if_min.push_id_o), 0);
    tick();
    check("post-rst count", int'(if_min.count_o), 1);
    check("post-rst head id", int'(if_min.pop_id_o), 0);
    check("post-rst head data", int'(if_min.pop_data_o), 9);
    cycle(0, 0, 0, 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
